miriscv_fetch_buffer: RTL and testbench
=======================================

MIRISCV_FETCH_BUFFER -- requirements
Module: miriscv_fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 2, number of instruction entries; legal range 2..8 and need not be a power of two.
REQ-002 Parameters XLEN and ILEN SHALL be taken from miriscv_pkg.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 arstn_i  input  1  reset, asynchronous, active-low.
REQ-005 fetch_rvalid_i  input  1  fetch stage presents a valid fetched instruction this cycle.
REQ-006 fetch_instr_i  input  ILEN  fetched instruction word.
REQ-007 fetch_pc_i  input  XLEN  address of the fetched instruction.
REQ-008 fetch_pc_next_i  input  XLEN  sequential next address (pc+4).
REQ-009 flush_i  input  1  control-unit redirect; discards all buffered entries.
REQ-010 decode_ready_i  input  1  decode stage accepts the head entry this cycle.
REQ-011 decode_valid_o  output  1  head entry valid.
REQ-012 decode_instr_o / decode_pc_o / decode_pc_next_o  output  ILEN/XLEN/XLEN  head entry fields.
REQ-013 full_o  output  1  count == DEPTH; used by the control unit to stall fetch.
REQ-014 count_o  output  4  number of occupied entries.
REQ-015 overflow_o  output  1  sticky flag: a push was dropped because the buffer was full.

Function
REQ-016 The block SHALL be a circular FIFO with read pointer, write pointer and occupancy counter, all registered.
REQ-017 Push SHALL occur when fetch_rvalid_i=1, flush_i=0 and count<DEPTH, writing {instr, pc, pc_next} at the write pointer.
REQ-018 Pop SHALL occur when decode_valid_o=1, decode_ready_i=1 and flush_i=0, advancing the read pointer.
REQ-019 Pointers SHALL wrap from DEPTH-1 to 0 explicitly, with no reliance on power-of-two overflow.
REQ-020 Simultaneous push and pop SHALL leave count unchanged.
REQ-021 When count==DEPTH, a push SHALL be accepted only if a pop occurs in the same cycle.
REQ-022 A push attempted at count==DEPTH without a same-cycle pop SHALL be dropped, SHALL set overflow_o on the next edge, and SHALL leave the contents unchanged.
REQ-023 decode_valid_o SHALL be (count!=0) & ~flush_i.
REQ-024 decode_* data outputs SHALL come from the head entry; their value is don't-care while decode_valid_o=0.
REQ-025 flush_i=1 SHALL reset both pointers and count to 0 on the next edge, and any same-cycle push SHALL be discarded.
REQ-026 flush_i SHALL take priority over push, pop and overflow detection.
REQ-027 full_o and count_o SHALL be derived from registered count only, with no combinational path from any input.
REQ-028 Pop on an empty buffer SHALL be impossible by construction (REQ-023).

Reset
REQ-029 On arstn_i=0: pointers=0, count=0, overflow_o=0, decode_valid_o=0, full_o=0, count_o=0, regardless of other inputs.
REQ-030 Reset asserted mid-operation SHALL discard all entries immediately; the storage array need not be reset.
REQ-031 After deassertion, the first push SHALL be accepted on the first rising edge.

Configuration
REQ-032 Macro MIRISCV_FETCH_BUFFER_BYPASS_EN SHALL control the empty-buffer bypass path.
REQ-033 With the macro defined and count==0, fetch_rvalid_i=1 and flush_i=0: decode_valid_o=1 in the same cycle with decode_* = fetch_* inputs.
REQ-034 Under bypass, if decode_ready_i=1 the entry SHALL be consumed with no write and count stays 0; otherwise it SHALL be pushed normally.
REQ-035 Without the macro, latency from push to decode_valid_o SHALL be exactly one cycle, and decode_valid_o SHALL depend on registered state and flush_i only.

Verification
REQ-036 Reset, then push 0x00000013@pc 0x0 with ready=0 -> next cycle decode_valid_o=1, instr=0x00000013, pc=0x0, pc_next=0x4, count_o=1.
REQ-037 DEPTH=2, push 3 consecutive instrs with ready=0 -> count_o=2, full_o=1, overflow_o=1, head remains the first instr.
REQ-038 Full buffer, push+pop same cycle for 6 cycles -> count stays 2, pointers wrap, outputs appear in strict push order.
REQ-039 count=2, flush_i=1 with simultaneous push -> decode_valid_o=0 that cycle, count_o=0 next cycle, the pushed instr is never output.
REQ-040 BYPASS_EN defined, empty, push 0x00100093 with ready=1 -> same-cycle decode_valid_o=1 with that instr, count_o stays 0; undefined -> valid one cycle later.
REQ-041 arstn_i low while count=2 -> decode_valid_o=0, count_o=0, overflow_o=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/miriscv_fetch_buffer.sv
// Fetch-to-decode instruction buffer: circular FIFO of {instr, pc, pc_next}.
// Optional same-cycle empty bypass enabled by macro MIRISCV_FETCH_BUFFER_BYPASS_EN.

package miriscv_pkg;
    parameter int unsigned XLEN = 32;
    parameter int unsigned ILEN = 32;
endpackage

module miriscv_fetch_buffer
    import miriscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            fetch_rvalid_i,
    input  logic [ILEN-1:0] fetch_instr_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    input  logic [XLEN-1:0] fetch_pc_next_i,
    input  logic            flush_i,
    input  logic            decode_ready_i,
    output logic            decode_valid_o,
    output logic [ILEN-1:0] decode_instr_o,
    output logic [XLEN-1:0] decode_pc_o,
    output logic [XLEN-1:0] decode_pc_next_o,
    output logic            full_o,
    output logic [3:0]      count_o,
    output logic            overflow_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ILEN-1:0] r_instr   [DEPTH];
    logic [XLEN-1:0] r_pc      [DEPTH];
    logic [XLEN-1:0] r_pc_next [DEPTH];

    logic [PW-1:0]   r_rptr;
    logic [PW-1:0]   r_wptr;
    logic [3:0]      r_count;
    logic            r_overflow;

    logic            w_empty;
    logic            w_full;
    logic            w_head_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_write;
    logic            w_drop;
    logic            w_bypass;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_empty      = (r_count == 4'd0);
    assign w_full       = (r_count == 4'(DEPTH));
    assign w_head_valid = ~w_empty & ~flush_i;
    assign w_pop        = w_head_valid & decode_ready_i;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign w_push       = fetch_rvalid_i & ~flush_i & (~w_full | w_pop);
    assign w_drop       = fetch_rvalid_i & ~flush_i & w_full & ~w_pop;

`ifdef MIRISCV_FETCH_BUFFER_BYPASS_EN
    assign w_bypass       = w_empty & fetch_rvalid_i & ~flush_i;
    assign w_write        = w_push & ~(w_bypass & decode_ready_i);
    assign decode_valid_o = w_head_valid | w_bypass;
    assign decode_instr_o   = w_bypass ? fetch_instr_i   : r_instr[r_rptr];
    assign decode_pc_o      = w_bypass ? fetch_pc_i      : r_pc[r_rptr];
    assign decode_pc_next_o = w_bypass ? fetch_pc_next_i : r_pc_next[r_rptr];
`else
    assign w_bypass       = 1'b0;
    assign w_write        = w_push & ~w_bypass;
    assign decode_valid_o = w_head_valid;
    assign decode_instr_o   = r_instr[r_rptr];
    assign decode_pc_o      = r_pc[r_rptr];
    assign decode_pc_next_o = r_pc_next[r_rptr];
`endif

    assign full_o     = w_full;
    assign count_o    = r_count;
    assign overflow_o = r_overflow;

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (w_write) begin
            r_instr[r_wptr]   <= fetch_instr_i;
            r_pc[r_wptr]      <= fetch_pc_i;
            r_pc_next[r_wptr] <= fetch_pc_next_i;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_write) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_write && !w_pop) begin
                r_count <= r_count + 4'd1;
            end else if (!w_write && w_pop) begin
                r_count <= r_count - 4'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_miriscv_fetch_buffer.sv
// Scoreboard bench for miriscv_fetch_buffer: driver queues expected entries, negedge monitor compares.
module tb_miriscv_fetch_buffer;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        arstn;
    logic        rv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        fl;
    logic        rdy;
    logic        decode_valid_o;
    logic [31:0] decode_instr_o;
    logic [31:0] decode_pc_o;
    logic [31:0] decode_pc_next_o;
    logic        full_o;
    logic [3:0]  count_o;
    logic        overflow_o;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_next;
    } entry_t;

    entry_t exp_q[$];
    logic   exp_ovf;
    int     errors = 0;
    int     checks = 0;

    miriscv_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i           (clk),
        .arstn_i         (arstn),
        .fetch_rvalid_i  (rv),
        .fetch_instr_i   (instr),
        .fetch_pc_i      (pc),
        .fetch_pc_next_i (pc_next),
        .flush_i         (fl),
        .decode_ready_i  (rdy),
        .decode_valid_o  (decode_valid_o),
        .decode_instr_o  (decode_instr_o),
        .decode_pc_o     (decode_pc_o),
        .decode_pc_next_o(decode_pc_next_o),
        .full_o          (full_o),
        .count_o         (count_o),
        .overflow_o      (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT against the queue-based model once per cycle.
    always @(negedge clk) begin
        int     sz;
        logic   byp;
        logic   exp_v;
        entry_t e;
        sz  = exp_q.size();
`ifdef MIRISCV_FETCH_BUFFER_BYPASS_EN
        byp = arstn && sz == 0 && rv && !fl;
`else
        byp = 1'b0;
`endif
        exp_v = arstn && ((sz != 0 && !fl) || byp);
        chk("valid", 32'(decode_valid_o), 32'(exp_v));
        chk("count", 32'(count_o), 32'(sz));
        chk("full", 32'(full_o), 32'(sz == DEPTH));
        chk("overflow", 32'(overflow_o), 32'(exp_ovf));
        if (exp_v && decode_valid_o) begin
            e = byp ? entry_t'{instr, pc, pc_next} : exp_q[0];
            chk("instr", decode_instr_o, e.instr);
            chk("pc", decode_pc_o, e.pc);
            chk("pc_next", decode_pc_next_o, e.pc_next);
        end
        if (arstn && sz != 0 && !fl && rdy) begin
            void'(exp_q.pop_front());
        end
    end

    // Called at posedge+1; applies the model's view of the next edge afterwards.
    task automatic cycle(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic f, input logic r);
        int   sz;
        logic acc;
        logic drop;
        rv = v; instr = i; pc = p; pc_next = p + 32'd4; fl = f; rdy = r;
        sz   = exp_q.size();
        acc  = v && !f && (sz < DEPTH || (sz != 0 && r));
        drop = v && !f && sz == DEPTH && !r;
`ifdef MIRISCV_FETCH_BUFFER_BYPASS_EN
        if (sz == 0 && v && !f && r) acc = 1'b0;
`endif
        @(posedge clk);
        #1;
        if (f) exp_q.delete();
        else if (acc) exp_q.push_back(entry_t'{i, p, p + 32'd4});
        if (drop) exp_ovf = 1'b1;
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        rv = 1'b0; instr = '0; pc = '0; pc_next = '0; fl = 1'b0; rdy = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arstn = 1'b1;
    endtask

    initial begin
        exp_ovf = 1'b0;
        arstn = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // single push, head visible one cycle later
        cycle(1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // overfill: third push dropped, head stays first
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'h100 + 32'(k), 32'(k * 4), 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // full, push+pop each cycle for 6 cycles
        for (int k = 0; k < 6; k++) cycle(1'b1, 32'h200 + 32'(k), 32'h1000 + 32'(k * 4), 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // flush with simultaneous push while full
        cycle(1'b1, 32'hDEAD_BEEF, 32'h2000, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // empty buffer push with ready high
        cycle(1'b1, 32'h0010_0093, 32'h3000, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        do_reset();
        for (int k = 0; k < 500; k++) begin
            cycle($urandom_range(0, 9) < 7, $urandom, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
        end

        // asynchronous reset while full with overflow set
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'h300 + 32'(k), 32'(k * 4), 1'b0, 1'b0);
        #1;
        arstn = 1'b0;
        #1;
        chk("async_valid", 32'(decode_valid_o), 32'd0);
        chk("async_count", 32'(count_o), 32'd0);
        chk("async_overflow", 32'(overflow_o), 32'd0);
        chk("async_full", 32'(full_o), 32'd0);
        exp_q.delete();
        exp_ovf = 1'b0;
        rv = 1'b0; fl = 1'b0; rdy = 1'b0;
        @(posedge clk);
        #1;
        arstn = 1'b1;
        cycle(1'b1, 32'h0000_0013, 32'h40, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
